pattern_gen: RTL and testbench

- Serial pattern transmitter. Drives a registered single-bit stream that feeds the `pattern` sequence detector; it is the source end of the same serial line.
- Loads a PAT_W-bit pattern and shifts it out MSB-first, once per clock.
- Repeats the pattern a programmed number of times, with a programmable number of idle-0 gap bits between repetitions.
- Used as the synthesizable stimulus source for detector regressions and on-chip loopback.

---
 rtl/pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_pattern_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first, repeated
// `reps` times with `gap` idle-0 bits between repetitions. Define PGEN_PARITY_EN
// to append an even-parity bit after each repetition.
module pattern_gen #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] reps,
  input  logic [3:0]       gap,
  output logic             o,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

`ifdef PGEN_PARITY_EN
  typedef enum logic [2:0] {IDLE, SEND, GAP, DONE, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, GAP, DONE} state_t;
`endif

  state_t           state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [PAT_W-1:0] pat_reg, pat_n;
  logic [PAT_W-1:0] pat_sel;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic [3:0]       gap_reg, gap_reg_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic             o_n, busy_n, done_n;
  logic             rep_end, rem_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_reg <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      gap_reg <= '0;
      gap_cnt <= '0;
      o       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      pat_reg <= pat_n;
      bit_idx <= bit_idx_n;
      rep_cnt <= rep_n;
      gap_reg <= gap_reg_n;
      gap_cnt <= gap_cnt_n;
      o       <= o_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    pat_n     = pat_reg;
    bit_idx_n = bit_idx;
    rep_n     = rep_cnt;
    gap_reg_n = gap_reg;
    gap_cnt_n = gap_cnt;
    o_n       = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    rep_end   = 1'b0;
    rem_zero  = 1'b0;
    pat_sel   = use_def ? PAT_RST : pat_in;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (reps == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = SEND;
            pat_n     = pat_sel;
            shreg_n   = {pat_sel[PAT_W-2:0], 1'b0};
            o_n       = pat_sel[PAT_W-1];
            bit_idx_n = IDX_W'(PAT_W - 1);
            rep_n     = reps;
            gap_reg_n = gap;
            busy_n    = 1'b1;
          end
        end
      end
      SEND: begin
        busy_n = 1'b1;
        if (bit_idx != '0) begin
          o_n       = shreg[PAT_W-1];
          shreg_n   = {shreg[PAT_W-2:0], 1'b0};
          bit_idx_n = bit_idx - IDX_W'(1);
        end else begin
          rep_n = rep_cnt - CNT_W'(1);
`ifdef PGEN_PARITY_EN
          state_n = PARITY;
          o_n     = ^pat_reg;
`else
          rep_end  = 1'b1;
          rem_zero = (rep_cnt == CNT_W'(1));
`endif
        end
      end
`ifdef PGEN_PARITY_EN
      // Reps counter was already decremented on bit 0, so test it for zero here.
      PARITY: begin
        busy_n   = 1'b1;
        rep_end  = 1'b1;
        rem_zero = (rep_cnt == '0);
      end
`endif
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == '0) begin
          state_n   = SEND;
          shreg_n   = {pat_reg[PAT_W-2:0], 1'b0};
          o_n       = pat_reg[PAT_W-1];
          bit_idx_n = IDX_W'(PAT_W - 1);
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // End of one repetition: finish, reload back-to-back, or insert the gap.
    if (rep_end) begin
      if (rem_zero) begin
        state_n = DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        o_n     = 1'b0;
      end else if (gap_reg == '0) begin
        state_n   = SEND;
        shreg_n   = {pat_reg[PAT_W-2:0], 1'b0};
        o_n       = pat_reg[PAT_W-1];
        bit_idx_n = IDX_W'(PAT_W - 1);
        busy_n    = 1'b1;
      end else begin
        state_n   = GAP;
        gap_cnt_n = gap_reg - 4'd1;
        o_n       = 1'b0;
        busy_n    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed, table-driven bench for pattern_gen: stream contents, busy length,
// done pulse position, plus ignored-start and mid-stream reset sequences.
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, start, use_def;
  logic [3:0] pat_in;
  logic [7:0] reps;
  logic [3:0] gap;
  logic       o, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_gen #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .use_def(use_def), .pat_in(pat_in),
    .reps(reps), .gap(gap), .o(o), .busy(busy), .done(done)
  );

  typedef struct {
    logic        use_def;
    logic [3:0]  pat;
    logic [7:0]  reps;
    logic [3:0]  gap;
    int          len;
    logic [63:0] bits;
    int          det;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic observe(input int win, output int n_busy, output int done_cnt,
                         output int done_at, output int o_bad,
                         output logic [63:0] bits, output int det);
    logic [3:0] w;
    w = '0; n_busy = 0; done_cnt = 0; done_at = -1; o_bad = 0; bits = '0; det = 0;
    for (int j = 0; j < win; j++) begin
      @(negedge clk);
      w = {w[2:0], o};
      if (w == 4'b1101) det++;
      if (busy) begin
        bits = {bits[62:0], o};
        n_busy++;
        if (done) o_bad++;
      end else if (o) begin
        o_bad++;
      end
      if (done) begin
        if (done_cnt == 0) done_at = j;
        done_cnt++;
      end
    end
  endtask

  task automatic run_vec(input vec_t t, input string tag, input bit mess);
    int n_busy, done_cnt, done_at, o_bad, det;
    logic [63:0] bits, m;
    @(negedge clk);
    use_def = t.use_def; pat_in = t.pat; reps = t.reps; gap = t.gap; start = 1'b1;
    fork
      observe(t.len + 20, n_busy, done_cnt, done_at, o_bad, bits, det);
      begin
        @(negedge clk);
        start = 1'b0;
        if (mess) begin
          repeat (2) @(negedge clk);
          start = 1'b1; pat_in = 4'b0000; use_def = ~t.use_def; reps = 8'd7; gap = 4'd9;
          @(negedge clk);
          start = 1'b0;
          repeat (t.len - 3) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    m = (t.len >= 64) ? '1 : ((64'd1 << t.len) - 64'd1);
    if (t.len > 0) chk($sformatf("%s.bits", tag), bits & m, t.bits & m);
    chk($sformatf("%s.busy_cycles", tag), 64'(n_busy), 64'(t.len));
    chk($sformatf("%s.done_count", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s.done_at", tag), 64'(done_at), 64'(t.len));
    chk($sformatf("%s.o_outside_busy", tag), 64'(o_bad), 64'd0);
    if (t.det >= 0) chk($sformatf("%s.detect_1101", tag), 64'(det), 64'(t.det));
  endtask

  initial begin
    int n_busy, done_cnt, done_at, o_bad, det;
    logic [63:0] bits;

`ifdef PGEN_PARITY_EN
    v[0] = '{1'b1, 4'b0000, 8'd2,   4'd1,  11,   64'({5'b11011, 1'b0, 5'b11011}), -1};
    v[1] = '{1'b0, 4'b1001, 8'd3,   4'd0,  15,   64'({3{5'b10010}}), -1};
    v[2] = '{1'b1, 4'b1111, 8'd0,   4'd3,  0,    64'd0, -1};
    v[3] = '{1'b0, 4'b0110, 8'd1,   4'd5,  5,    64'(5'b01100), -1};
    v[4] = '{1'b0, 4'b1000, 8'd2,   4'd3,  13,   64'({5'b10001, 3'b000, 5'b10001}), -1};
    v[5] = '{1'b0, 4'b1111, 8'd2,   4'd15, 25,   64'({5'b11110, 15'd0, 5'b11110}), -1};
    v[6] = '{1'b1, 4'b0000, 8'd3,   4'd0,  15,   64'({3{5'b11011}}), 3};
    v[7] = '{1'b1, 4'b0000, 8'd255, 4'd0,  1275, {4'b1011, {12{5'b11011}}}, -1};
    v[8] = '{1'b1, 4'b0010, 8'd1,   4'd0,  5,    64'(5'b11011), -1};
`else
    v[0] = '{1'b1, 4'b0000, 8'd2,   4'd1,  9,    64'(9'b110101101), -1};
    v[1] = '{1'b0, 4'b1001, 8'd3,   4'd0,  12,   64'({3{4'b1001}}), -1};
    v[2] = '{1'b1, 4'b1111, 8'd0,   4'd3,  0,    64'd0, -1};
    v[3] = '{1'b0, 4'b0110, 8'd1,   4'd5,  4,    64'(4'b0110), -1};
    v[4] = '{1'b0, 4'b1000, 8'd2,   4'd3,  11,   64'({4'b1000, 3'b000, 4'b1000}), -1};
    v[5] = '{1'b0, 4'b1111, 8'd2,   4'd15, 23,   64'({4'b1111, 15'd0, 4'b1111}), -1};
    v[6] = '{1'b1, 4'b0000, 8'd3,   4'd0,  12,   64'({3{4'b1101}}), 3};
    v[7] = '{1'b1, 4'b0000, 8'd255, 4'd0,  1020, {16{4'b1101}}, -1};
    v[8] = '{1'b1, 4'b0010, 8'd1,   4'd0,  4,    64'(4'b1101), -1};
`endif

    rst = 1'b1; start = 1'b0; use_def = 1'b0; pat_in = '0; reps = '0; gap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.o", 64'(o), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(v[i], $sformatf("vec%0d", i), 1'b0);

    run_vec(v[0], "ignored_start", 1'b1);

    // Reset while the third bit is on the line
    @(negedge clk);
    use_def = 1'b1; reps = 8'd2; gap = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrst.first_bit", 64'(o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.o", 64'(o), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    rst = 1'b0;
    observe(20, n_busy, done_cnt, done_at, o_bad, bits, det);
    chk("midrst.no_done", 64'(done_cnt), 64'd0);
    chk("midrst.quiet", 64'(n_busy + o_bad), 64'd0);
    run_vec(v[0], "after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
